// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : In-order instruction fetch front end with a credit-limited
//            prefetch FIFO and redirect flush of stale in-flight responses.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
);

    localparam int              c_AW   = $clog2(FIFO_DEPTH);
    localparam int              c_CW   = c_AW + 1;
    localparam int              c_SW   = c_CW + 1;
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_SW-1:0] c_CAP  = c_SW'(FIFO_DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_discard;
    logic [c_CW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_rd_ptr;
    logic [64:0]     r_fifo [FIFO_DEPTH];

    logic [c_CW-1:0] w_count;
    logic [c_SW-1:0] w_used;
    logic            w_empty;
    logic            w_full;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_rsp_keep;
    logic            w_pop;
    logic [c_CW-1:0] w_out_next;
    logic [31:0]     w_target;
    logic [64:0]     w_head;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_count == c_FULL);
    // Credits cover both in-flight requests and buffered words, so every
    // response that is kept always finds a free FIFO slot.
    assign w_used   = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_target = redirect_pc & ~32'h0000_0003;

    assign imem_req_valid = !rst && !redirect_valid && (w_used < c_CAP);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response arriving with nothing outstanding is ignored entirely.
    assign w_rsp_take = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_take && (r_discard == '0) && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign w_out_next = r_outstanding + c_CW'(w_req_fire) - c_CW'(w_rsp_take);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the
                // old stream and must be dropped on arrival.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= w_out_next;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_rsp_take && (r_discard != '0)) begin
                    r_discard <= r_discard - c_ONE;
                end
                if (w_rsp_keep) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= r_wr_ptr + c_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_keep) begin
            r_fifo[r_wr_ptr[c_AW-1:0]] <= {r_resp_pc, imem_rsp_data, imem_rsp_err};
        end
    end

    assign w_head     = r_fifo[r_rd_ptr[c_AW-1:0]];
    assign inst_valid = !w_empty;
    assign inst_pc    = inst_valid ? w_head[64:33] : 32'h0;
    assign inst_data  = inst_valid ? w_head[32:1]  : 32'h0;
    assign inst_fault = inst_valid ? w_head[0]     : 1'b0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp_keep && w_full));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] A_FAULT = 32'h0000_0108;
    localparam logic [31:0] B_FAULT = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req_valid, a_req_ready = 1'b0;
    logic [31:0] a_req_addr;
    logic        a_rsp_valid = 1'b0, a_rsp_err = 1'b0;
    logic [31:0] a_rsp_data = 32'h0;
    logic        a_redir = 1'b0;
    logic [31:0] a_redir_pc = 32'h0;
    logic        a_inst_valid, a_inst_ready = 1'b0, a_inst_fault;
    logic [31:0] a_inst_data, a_inst_pc;

    logic        b_req_valid, b_req_ready = 1'b1;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid = 1'b0, b_rsp_err = 1'b0;
    logic [31:0] b_rsp_data = 32'h0;
    logic        b_redir = 1'b0;
    logic [31:0] b_redir_pc = 32'h0;
    logic        b_inst_valid, b_inst_ready = 1'b1, b_inst_fault;
    logic [31:0] b_inst_data, b_inst_pc;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 0;
    logic [31:0] exp_pc  = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend [$];

    // ctl = {req_ready, inst_ready, redirect}, ev = {req_valid, inst_valid}
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] rpc;
        logic [1:0]  ev;
        logic [31:0] eaddr;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl [21];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data), .imem_rsp_err(a_rsp_err),
        .redirect_valid(a_redir), .redirect_pc(a_redir_pc),
        .inst_valid(a_inst_valid), .inst_ready(a_inst_ready), .inst_data(a_inst_data),
        .inst_pc(a_inst_pc), .inst_fault(a_inst_fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data), .imem_rsp_err(b_rsp_err),
        .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
        .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data),
        .inst_pc(b_inst_pc), .inst_fault(b_inst_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] rpc,
                                input logic [1:0] ev, input logic [31:0] eaddr,
                                input logic [31:0] epc);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.ev = ev; v.eaddr = eaddr; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory for DUT A: in-order, fixed latency, one response per cycle.
    initial forever begin
        @(negedge clk); #2;
        if (rst) begin
            pend.delete();
            a_rsp_valid = 1'b0; a_rsp_data = 32'h0; a_rsp_err = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                a_rsp_valid = 1'b1;
                a_rsp_data  = mem_word(pend[0].addr);
                a_rsp_err   = (pend[0].addr == A_FAULT);
                void'(pend.pop_front());
            end else begin
                a_rsp_valid = 1'b0; a_rsp_data = 32'h0; a_rsp_err = 1'b0;
            end
            if (a_req_valid && a_req_ready)
                pend.push_back('{addr: a_req_addr, due: cyc + 1 + lat});
        end
    end

    // Memory for DUT B: zero-wait, always ready.
    initial begin : b_mem
        logic        b_pend;
        logic [31:0] b_paddr;
        b_pend = 1'b0; b_paddr = 32'h0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                b_pend = 1'b0;
                b_rsp_valid = 1'b0; b_rsp_data = 32'h0; b_rsp_err = 1'b0;
            end else begin
                b_rsp_valid = b_pend;
                b_rsp_data  = b_pend ? mem_word(b_paddr) : 32'h0;
                b_rsp_err   = b_pend && (b_paddr == B_FAULT);
                b_pend      = b_req_valid;
                b_paddr     = b_req_addr;
            end
        end
    end

    // One cycle of DUT A stimulus plus in-order stream scoreboard.
    task automatic step(input logic [2:0] ctl, input logic [31:0] rpc);
        @(negedge clk);
        rst = 1'b0;
        a_req_ready = ctl[2]; a_inst_ready = ctl[1]; a_redir = ctl[0]; a_redir_pc = rpc;
        #3;
        if (ctl[0]) begin
            exp_pc = rpc & ~32'h3;
        end else if (a_inst_valid && ctl[1]) begin
            chk("sb_pc", a_inst_pc, exp_pc);
            chk("sb_data", a_inst_data, mem_word(exp_pc));
            chk("sb_fault", {31'h0, a_inst_fault}, {31'h0, exp_pc == A_FAULT});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset(input int latency);
        @(negedge clk);
        rst = 1'b1;
        a_req_ready = 1'b0; a_inst_ready = 1'b0; a_redir = 1'b0; a_redir_pc = 32'h0;
        lat = latency;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_valid", {31'h0, a_req_valid}, 32'h0);
        chk("rst_req_addr", a_req_addr, 32'h0);
        chk("rst_inst_valid", {31'h0, a_inst_valid}, 32'h0);
        chk("rst_inst_pc", a_inst_pc, 32'h0);
        chk("rst_inst_data", a_inst_data, 32'h0);
        chk("rst_inst_fault", {31'h0, a_inst_fault}, 32'h0);
        chk("rst_b_req_addr", b_req_addr, 32'hFFFF_FFF8);
        chk("rst_b_inst_valid", {31'h0, b_inst_valid}, 32'h0);
        exp_pc = 32'h0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  waited;
        bit  seen;

        tbl[0]  = mk(3'b100, 32'h0,   2'b10, 32'h000, 32'h000);
        tbl[1]  = mk(3'b100, 32'h0,   2'b10, 32'h004, 32'h000);
        tbl[2]  = mk(3'b100, 32'h0,   2'b11, 32'h008, 32'h000);
        tbl[3]  = mk(3'b100, 32'h0,   2'b11, 32'h00C, 32'h000);
        tbl[4]  = mk(3'b100, 32'h0,   2'b01, 32'h010, 32'h000);
        tbl[5]  = mk(3'b100, 32'h0,   2'b01, 32'h010, 32'h000);
        tbl[6]  = mk(3'b110, 32'h0,   2'b01, 32'h010, 32'h000);
        tbl[7]  = mk(3'b110, 32'h0,   2'b11, 32'h010, 32'h004);
        tbl[8]  = mk(3'b110, 32'h0,   2'b11, 32'h014, 32'h008);
        tbl[9]  = mk(3'b110, 32'h0,   2'b11, 32'h018, 32'h00C);
        tbl[10] = mk(3'b110, 32'h0,   2'b11, 32'h01C, 32'h010);
        tbl[11] = mk(3'b110, 32'h0,   2'b11, 32'h020, 32'h014);
        tbl[12] = mk(3'b111, 32'h103, 2'b01, 32'h024, 32'h018);
        tbl[13] = mk(3'b110, 32'h0,   2'b10, 32'h100, 32'h000);
        tbl[14] = mk(3'b110, 32'h0,   2'b10, 32'h104, 32'h000);
        tbl[15] = mk(3'b110, 32'h0,   2'b11, 32'h108, 32'h100);
        tbl[16] = mk(3'b111, 32'h200, 2'b01, 32'h10C, 32'h104);
        tbl[17] = mk(3'b111, 32'h300, 2'b00, 32'h200, 32'h000);
        tbl[18] = mk(3'b110, 32'h0,   2'b10, 32'h300, 32'h000);
        tbl[19] = mk(3'b110, 32'h0,   2'b10, 32'h304, 32'h000);
        tbl[20] = mk(3'b110, 32'h0,   2'b11, 32'h308, 32'h300);

        // Zero-wait memory: fill with inst_ready low, drain, then redirects.
        do_reset(0);
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].ctl, tbl[i].rpc);
            chk($sformatf("t%0d_req_valid", i), {31'h0, a_req_valid}, {31'h0, tbl[i].ev[1]});
            chk($sformatf("t%0d_req_addr", i), a_req_addr, tbl[i].eaddr);
            chk($sformatf("t%0d_inst_valid", i), {31'h0, a_inst_valid}, {31'h0, tbl[i].ev[0]});
            if (tbl[i].ev[0]) begin
                chk($sformatf("t%0d_inst_pc", i), a_inst_pc, tbl[i].epc);
                chk($sformatf("t%0d_inst_data", i), a_inst_data, mem_word(tbl[i].epc));
                chk($sformatf("t%0d_inst_fault", i), {31'h0, a_inst_fault}, 32'h0);
            end else begin
                chk($sformatf("t%0d_idle_pc", i), a_inst_pc, 32'h0);
                chk($sformatf("t%0d_idle_data", i), a_inst_data, 32'h0);
                chk($sformatf("t%0d_idle_fault", i), {31'h0, a_inst_fault}, 32'h0);
            end
        end

        // Latency-4 memory, three requests in flight, then one or two redirects.
        for (int v = 0; v < 2; v++) begin
            do_reset(3);
            repeat (3) step(3'b110, 32'h0);
            if (v == 1) step(3'b111, 32'h200);
            step(3'b111, 32'h100);
            step(3'b110, 32'h0);
            chk($sformatf("redir%0d_first_req_valid", v), {31'h0, a_req_valid}, 32'h1);
            chk($sformatf("redir%0d_first_req_addr", v), a_req_addr, 32'h100);
            waited = 1;
            seen   = a_inst_valid;
            while (!seen && waited < 20) begin
                step(3'b110, 32'h0);
                waited++;
                seen = a_inst_valid;
            end
            chk($sformatf("redir%0d_inst_seen", v), {31'h0, seen}, 32'h1);
            chk($sformatf("redir%0d_latency", v), waited, 32'd6);
            repeat (8) step(3'b110, 32'h0);
        end

        // Request channel stalled for five cycles: address must hold.
        do_reset(0);
        for (int k = 0; k < 5; k++) begin
            step(3'b010, 32'h0);
            chk($sformatf("stall%0d_req_valid", k), {31'h0, a_req_valid}, 32'h1);
            chk($sformatf("stall%0d_req_addr", k), a_req_addr, 32'h0);
        end
        step(3'b110, 32'h0);
        chk("stall_fire_addr", a_req_addr, 32'h0);
        step(3'b110, 32'h0);
        chk("stall_next_addr", a_req_addr, 32'h4);
        repeat (6) step(3'b110, 32'h0);

        // DUT B: reset PC near the top of memory, wrap, and a faulting word.
        do_reset(0);
        step(3'b110, 32'h0);
        chk("b_s0_req_valid", {31'h0, b_req_valid}, 32'h1);
        chk("b_s0_req_addr", b_req_addr, 32'hFFFF_FFF8);
        step(3'b110, 32'h0);
        chk("b_s1_req_addr", b_req_addr, 32'hFFFF_FFFC);
        chk("b_s1_inst_valid", {31'h0, b_inst_valid}, 32'h0);
        step(3'b110, 32'h0);
        chk("b_s2_req_addr", b_req_addr, 32'h0000_0000);
        chk("b_s2_inst_pc", b_inst_pc, 32'hFFFF_FFF8);
        chk("b_s2_inst_data", b_inst_data, mem_word(32'hFFFF_FFF8));
        chk("b_s2_inst_fault", {31'h0, b_inst_fault}, 32'h0);
        step(3'b110, 32'h0);
        chk("b_s3_inst_pc", b_inst_pc, 32'hFFFF_FFFC);
        chk("b_s3_inst_data", b_inst_data, mem_word(32'hFFFF_FFFC));
        chk("b_s3_inst_fault", {31'h0, b_inst_fault}, 32'h1);
        step(3'b110, 32'h0);
        chk("b_s4_inst_pc", b_inst_pc, 32'h0000_0000);
        chk("b_s4_inst_data", b_inst_data, mem_word(32'h0000_0000));
        chk("b_s4_inst_fault", {31'h0, b_inst_fault}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
